nbody_step_scheduler: RTL and testbench

//   Sequencer for the shared gravity micro-step datapath (one velocity adder, P/Q/axis muxes).
//   Per frame: one position-update strobe, then a sweep of all ordered body pairs.

---
 rtl/nbody_pkg.sv | 16 +
 rtl/nbody_step_scheduler_if.sv | 31 +++
 rtl/nbody_pair_iter.sv | 64 ++++++
 rtl/nbody_step_scheduler.sv | 96 +++++++++
 tb/tb_nbody_step_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nbody_pkg.sv
// Shared constants for the gravity micro-step sequencer: body count,
// step counts, index widths and the scheduler state encoding.
package nbody_pkg;

  localparam int N_BODIES        = 3;
  localparam int STEPS_PER_FRAME = 2 * N_BODIES * (N_BODIES - 1);
  localparam int BODY_W          = $clog2(N_BODIES);
  localparam int STEP_W          = $clog2(STEPS_PER_FRAME);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POS   = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/nbody_step_scheduler_if.sv
// Control inputs from video timing / user, and step commands to the physics
// datapath. The scheduler is the master; the datapath/environment is the slave.
interface nbody_step_scheduler_if;
  import nbody_pkg::*;

  logic              frame_tick;
  logic              video_active;
  logic              run_en;
  logic              single_step;
  logic              clr_overrun;
  logic              pos_upd;
  logic              step_valid;
  logic [BODY_W-1:0] p_sel;
  logic [BODY_W-1:0] q_sel;
  logic              axis;
  logic [STEP_W-1:0] step_idx;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    input  frame_tick, video_active, run_en, single_step, clr_overrun,
    output pos_upd, step_valid, p_sel, q_sel, axis, step_idx, busy, done, overrun
  );

  modport slave (
    output frame_tick, video_active, run_en, single_step, clr_overrun,
    input  pos_upd, step_valid, p_sel, q_sel, axis, step_idx, busy, done, overrun
  );

endinterface

// File: rtl/nbody_pair_iter.sv
// Walks every ordered body pair (P != Q), X then Y for each pair, and keeps
// a running step index. clear beats start beats advance.
module nbody_pair_iter
  import nbody_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic              advance,
  output logic [BODY_W-1:0] p,
  output logic [BODY_W-1:0] q,
  output logic              axis,
  output logic [STEP_W-1:0] idx,
  output logic              last
);

  localparam logic [BODY_W:0] NB = (BODY_W + 1)'(N_BODIES);

  logic [BODY_W:0] q_inc;
  logic [BODY_W:0] q_skip;

  // Next attracting body for the same P, stepping over Q == P.
  always_comb begin
    q_inc  = {1'b0, q} + 1'b1;
    q_skip = (q_inc == {1'b0, p}) ? q_inc + 1'b1 : q_inc;
    last   = (idx == STEP_W'(STEPS_PER_FRAME - 1));
  end

  // Pair/axis/index counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p    <= '0;
      q    <= '0;
      axis <= 1'b0;
      idx  <= '0;
    end else if (clear) begin
      p    <= '0;
      q    <= '0;
      axis <= 1'b0;
      idx  <= '0;
    end else if (start) begin
      p    <= '0;
      q    <= BODY_W'(1);
      axis <= 1'b0;
      idx  <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
      if (!axis) begin
        axis <= 1'b1;
      end else begin
        axis <= 1'b0;
        if (q_skip < NB) begin
          q <= q_skip[BODY_W-1:0];
        end else begin
          // New P is never 0 after an increment, so body 0 is its first Q.
          p <= p + 1'b1;
          q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/nbody_step_scheduler.sv
// Frame-level sequencer for the shared gravity micro-step datapath:
// one position strobe per accepted frame, then a blanking-only pair sweep.
// Handles run/pause, single-frame stepping, frame division and overrun.
module nbody_step_scheduler
  import nbody_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nbody_step_scheduler_if.master bus
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  state_t     state, state_next;
  logic [3:0] div_cnt;
  logic       armed;
  logic       div_last;
  logic       accept;
  logic       overrun_set;
  logic       step_valid;
  logic       last;
  logic       iter_clear;
  logic       iter_start;

  assign step_valid     = (state == SWEEP) & ~bus.video_active;
  assign bus.step_valid = step_valid;
  assign div_last       = (div_cnt == DIV_LAST);
  assign accept         = bus.frame_tick & div_last & (bus.run_en | armed);

  // Next-state logic; an accepted tick mid-frame restarts at POS and flags overrun.
  always_comb begin
    state_next  = state;
    overrun_set = 1'b0;
    case (state)
      IDLE: if (accept) state_next = POS;
      POS: begin
        if (accept) begin
          state_next  = POS;
          overrun_set = 1'b1;
        end else begin
          state_next = SWEEP;
        end
      end
      SWEEP: begin
        if (accept) begin
          state_next  = POS;
          overrun_set = 1'b1;
        end else if (step_valid && last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    iter_clear = (state_next != SWEEP);
    iter_start = (state == POS) && (state_next == SWEEP);
  end

  // State, divider, arm and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      armed       <= 1'b0;
      bus.pos_upd <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      state       <= state_next;
      bus.pos_upd <= (state_next == POS);
      bus.busy    <= (state_next != IDLE);
      bus.done    <= (state == SWEEP) && (state_next == IDLE);
      if (bus.frame_tick) div_cnt <= div_last ? 4'd0 : div_cnt + 4'd1;
      if (accept) armed <= 1'b0;
      else if (bus.single_step && !bus.run_en) armed <= 1'b1;
      if (overrun_set) bus.overrun <= 1'b1;
      else if (bus.clr_overrun) bus.overrun <= 1'b0;
    end
  end

  nbody_pair_iter u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (iter_clear),
    .start   (iter_start),
    .advance (step_valid),
    .p       (bus.p_sel),
    .q       (bus.q_sel),
    .axis    (bus.axis),
    .idx     (bus.step_idx),
    .last    (last)
  );

endmodule

// File: tb/tb_nbody_step_scheduler.sv
// Scoreboard bench for nbody_step_scheduler: each accepted tick pushes the
// full expected pair/axis/index sequence; a negedge monitor pops and compares.
module tb_nbody_step_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nbody_step_scheduler_if bus1 ();
  nbody_step_scheduler_if bus2 ();

  nbody_step_scheduler #(.FRAME_DIV(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus1));
  nbody_step_scheduler #(.FRAME_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_checks = 0;
  int n_pass   = 0;
  int step_cnt = 0;
  int pos_cnt  = 0;
  int done_cnt = 0;
  int pos2_cnt = 0;
  logic prev_last = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [13:0] outs1();
    return {bus1.pos_upd, bus1.step_valid, bus1.p_sel, bus1.q_sel, bus1.axis,
            bus1.step_idx, bus1.busy, bus1.done, bus1.overrun};
  endfunction

  // Expected order derived independently: nested loops over ordered pairs.
  task automatic push_sweep();
    int idx = 0;
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3; q++)
        if (p != q)
          for (int ax = 0; ax < 2; ax++) begin
            exp_q.push_back({4'(idx), 2'(p), 2'(q), 1'(ax)});
            idx++;
          end
  endtask

  // Monitor: step scoreboard, done timing, event counters.
  always @(negedge clk) begin
    if (bus1.done || prev_last) check("done_after_last", 32'(bus1.done), 32'(prev_last));
    prev_last <= bus1.step_valid && (bus1.step_idx == 4'd11);
    if (bus1.done) done_cnt <= done_cnt + 1;
    if (bus1.pos_upd) pos_cnt <= pos_cnt + 1;
    if (bus1.step_valid) begin
      step_cnt <= step_cnt + 1;
      if (exp_q.size() == 0) check("unexpected_step", 32'(exp_q.size()), 32'd1);
      else check("step", {23'd0, bus1.step_idx, bus1.p_sel, bus1.q_sel, bus1.axis},
                 {23'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) if (bus2.pos_upd) pos2_cnt <= pos2_cnt + 1;

  task automatic do_tick(input bit second);
    @(posedge clk); #1;
    if (second) bus2.frame_tick = 1'b1; else bus1.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus1.frame_tick = 1'b0;
    bus2.frame_tick = 1'b0;
  endtask

  task automatic wait_steps(input int target);
    for (int i = 0; i < 200 && step_cnt < target; i++) begin
      @(negedge clk); #1;
    end
    check("wait_steps", 32'(step_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!bus1.busy) break;
    end
    check("sweep_end", 32'(bus1.busy), 32'd0);
    @(negedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base, pbase, dbase, bad;
    bus1.frame_tick = 0; bus1.video_active = 0; bus1.run_en = 0;
    bus1.single_step = 0; bus1.clr_overrun = 0;
    bus2.frame_tick = 0; bus2.video_active = 0; bus2.run_en = 0;
    bus2.single_step = 0; bus2.clr_overrun = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs1()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_outs", 32'(outs1()), 32'd0);

    // 1: free-running sweep in order
    bus1.run_en = 1'b1;
    base = step_cnt; dbase = done_cnt;
    push_sweep();
    do_tick(0);
    check("t1_pos_upd", 32'(bus1.pos_upd), 32'd1);
    check("t1_busy", 32'(bus1.busy), 32'd1);
    wait_idle();
    check("t1_steps", 32'(step_cnt - base), 32'd12);
    check("t1_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check("t1_idx_reset", 32'(outs1()), 32'd0);

    // 2: blanking stall holds the index
    base = step_cnt;
    push_sweep();
    do_tick(0);
    wait_steps(base + 6);
    @(posedge clk); #1;
    bus1.video_active = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.step_valid || bus1.step_idx != 4'd6) bad++;
    end
    check("t2_stall_hold", 32'(bad), 32'd0);
    check("t2_steps_at_stall", 32'(step_cnt - base), 32'd6);
    @(posedge clk); #1;
    bus1.video_active = 1'b0;
    wait_idle();
    check("t2_steps", 32'(step_cnt - base), 32'd12);

    // 3: paused, then one armed frame
    bus1.run_en = 1'b0;
    pbase = pos_cnt; base = step_cnt;
    repeat (3) begin
      do_tick(0);
      repeat (3) @(posedge clk);
    end
    #1;
    check("t3_paused_pos", 32'(pos_cnt - pbase), 32'd0);
    check("t3_paused_busy", 32'(bus1.busy), 32'd0);
    @(posedge clk); #1; bus1.single_step = 1'b1;
    @(posedge clk); #1; bus1.single_step = 1'b0;
    push_sweep();
    do_tick(0);
    check("t3_step_pos_upd", 32'(bus1.pos_upd), 32'd1);
    wait_idle();
    check("t3_one_sweep", 32'(step_cnt - base), 32'd12);
    do_tick(0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_disarmed", 32'(pos_cnt - pbase), 32'd1);

    // 4: overrun on a tick mid-sweep
    bus1.run_en = 1'b1;
    base = step_cnt;
    push_sweep();
    do_tick(0);
    wait_steps(base + 7);
    @(posedge clk); #1; bus1.frame_tick = 1'b1;
    @(posedge clk); #1; bus1.frame_tick = 1'b0;
    check("t4_step7_issued", 32'(step_cnt - base), 32'd8);
    check("t4_dropped", 32'(exp_q.size()), 32'd4);
    exp_q.delete();
    push_sweep();
    check("t4_overrun", 32'(bus1.overrun), 32'd1);
    check("t4_pos_upd", 32'(bus1.pos_upd), 32'd1);
    check("t4_idx0", 32'(bus1.step_idx), 32'd0);
    wait_idle();
    check("t4_sticky", 32'(bus1.overrun), 32'd1);
    @(posedge clk); #1; bus1.clr_overrun = 1'b1;
    @(posedge clk); #1; bus1.clr_overrun = 1'b0;
    check("t4_cleared", 32'(bus1.overrun), 32'd0);

    // 5: frame division by 3
    bus2.run_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_tick(1);
      check("t5_div_pos_upd", 32'(bus2.pos_upd), 32'((i % 3) == 2));
      repeat (20) @(posedge clk);
    end
    #1;
    check("t5_pos_count", 32'(pos2_cnt), 32'd2);

    // 6: async reset mid-sweep
    base = step_cnt;
    push_sweep();
    do_tick(0);
    wait_steps(base + 4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 32'(outs1()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = step_cnt;
    push_sweep();
    do_tick(0);
    wait_idle();
    check("t6_full_sweep", 32'(step_cnt - base), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
